z2_cycle_tracker: RTL and testbench
===================================

Name: z2_cycle_tracker

Overview:
- Sits directly upstream of the Autoconfig/RAM/IDE decode logic.
- Synchronises the asynchronous Zorro II bus strobes (AS, UDS, LDS, RW) into the board clock domain and runs the per-cycle bus state machine that produces z2_state.
- Downstream blocks gate their data/dtack actions on Z2_DATA.
- Owns the board's DTACK output timing, with programmable wait states and a bus-hang timeout.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the strobe synchronisers (legal 2..3).
- WAIT_STATES, 0, extra clk cycles held in Z2_DATA before DTACK is driven for RAM/IDE cycles (0..7).
- TIMEOUT, 63, clk cycles in Z2_START/Z2_DATA before forcing Z2_END (6-bit counter).

Ports:
- clk  in  1  board clock (7M/CPU clock domain)
- reset  in  1  asynchronous, active-high reset
- as_n  in  1  Zorro II address strobe (async)
- uds_n  in  1  upper data strobe (async)
- lds_n  in  1  lower data strobe (async)
- rw  in  1  bus read(1)/write(0), sampled with AS
- board_select  in  1  OR of ram_access | ide_access | autoconfig_cycle from decode
- slave_ack  in  1  Autoconfig dtack pulse (one clk in Z2_DATA)
- z2_state  out  2  Z2_IDLE=2'b00, Z2_START=2'b01, Z2_DATA=2'b10, Z2_END=2'b11
- rw_latched  out  1  rw captured at Z2_START entry
- ds_active  out  1  synchronised (~uds_n | ~lds_n)
- dtack_n  out  1  board DTACK to bus (active low, registered)
- timeout  out  1  one-clk pulse when TIMEOUT expires

Behaviour:
- Reset (async, reset=1): z2_state=Z2_IDLE, dtack_n=1, rw_latched=1, ds_active=0, timeout=0, synchronisers filled with deasserted values (as=1, ds=1), counters=0.
- as_s / ds_s = outputs of SYNC_STAGES-deep chains; all FSM decisions use synchronised values only. Latency from an as_n edge to as_s is SYNC_STAGES clks.
- IDLE: as_s=0 -> START; capture rw_latched<=rw; clear wait and timeout counters.
- START: if as_s=1 (runt strobe) -> IDLE. Else if board_select=0 -> END (cycle not for us; dtack_n stays 1). Else, for rw_latched=1 go to DATA immediately; for rw_latched=0 go to DATA once ds_s=0 (write data valid).
- DATA: wait counter increments each clk.
  - Autoconfig path: slave_ack=1 -> dtack_n<=0, next END.
  - RAM/IDE path: when wait counter == WAIT_STATES -> dtack_n<=0, next END.
  - Z2_DATA lasts ≥1 clk; with WAIT_STATES=0, DATA is exactly 1 clk.
  - as_s=1 while in DATA (master aborted) -> IDLE, dtack_n stays 1.
- END: hold dtack_n at its current value until as_s=1. Then dtack_n<=1 and the next state is IDLE. A new AS cannot start until IDLE has been occupied for ≥1 clk.
- Timeout: 6-bit counter runs in START and DATA. When it reaches TIMEOUT: timeout=1 for one clk, next state END, dtack_n stays 1 (bus error left to host). Counter saturates and never wraps.
- Simultaneous events:
  - slave_ack and counter expiry in the same clk: single dtack assertion, no double-count.
  - as_s rising in the same clk as slave_ack: abort wins, return to IDLE, dtack_n=1.
- dtack_n is never 0 outside END. z2_state changes only on clk rising edge. Mid-cycle reset returns all outputs to reset values immediately.
- ds_active = ~ds_s, registered.

Test Plan:
- Read cycle, board_select=1, WAIT_STATES=0: as_n falls -> START at SYNC_STAGES+1 clks, DATA for 1 clk, dtack_n=0 in END. as_n rises -> dtack_n=1, IDLE after SYNC_STAGES+1 clks.
- Write cycle with DS delayed 3 clks after AS: state holds START until ds_s=0, then DATA. rw_latched=0 throughout.
- Autoconfig read with slave_ack pulsed on the 2nd DATA clk: DATA lasts exactly 2 clks, then END with dtack_n=0.
- Unselected cycle (board_select=0): START -> END, dtack_n stays 1 whole cycle, IDLE after AS release.
- Hang: board_select=1, WAIT_STATES=7, slave never acks, rw=0, DS never asserts: timeout pulses at count 63, state END, dtack_n=1.
- Reset asserted while in DATA with dtack pending: z2_state=00 and dtack_n=1 asynchronously; after reset release with as_n=0 still held, the FSM re-enters START only after as_s is synchronised.

Source files
------------

// File: rtl/z2_cycle_tracker_if.sv
// ============================================================================
// Module      : z2_cycle_tracker_if
// Description : Zorro II strobe inputs and cycle-tracker status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface z2_cycle_tracker_if;
    logic       as_n;
    logic       uds_n;
    logic       lds_n;
    logic       rw;
    logic       board_select;
    logic       slave_ack;
    logic [1:0] z2_state;
    logic       rw_latched;
    logic       ds_active;
    logic       dtack_n;
    logic       timeout;

    modport master (
        output as_n, uds_n, lds_n, rw, board_select, slave_ack,
        input  z2_state, rw_latched, ds_active, dtack_n, timeout
    );

    modport slave (
        input  as_n, uds_n, lds_n, rw, board_select, slave_ack,
        output z2_state, rw_latched, ds_active, dtack_n, timeout
    );
endinterface

`default_nettype wire

// File: rtl/z2_cycle_tracker.sv
// ============================================================================
// Module      : z2_cycle_tracker
// Description : Synchronises Zorro II strobes, tracks bus cycle, drives DTACK.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module z2_cycle_tracker #(
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT     = 63
) (
    input  wire logic          clk,
    input  wire logic          reset,
    z2_cycle_tracker_if.slave  bus
);

    typedef enum logic [1:0] {
        Z2_IDLE  = 2'b00,
        Z2_START = 2'b01,
        Z2_DATA  = 2'b10,
        Z2_END   = 2'b11
    } z2_state_e;

    localparam logic [2:0] c_wait_states = 3'(WAIT_STATES);
    localparam logic [5:0] c_timeout     = 6'(TIMEOUT);

    z2_state_e              state_q, state_d;
    logic [SYNC_STAGES-1:0] as_sync_q, as_sync_d;
    logic [SYNC_STAGES-1:0] ds_sync_q, ds_sync_d;
    logic                   rw_latched_q, rw_latched_d;
    logic                   ds_active_q, ds_active_d;
    logic                   dtack_n_q, dtack_n_d;
    logic                   timeout_q, timeout_d;
    logic [2:0]             wait_cnt_q, wait_cnt_d;
    logic [5:0]             tmo_cnt_q, tmo_cnt_d;

    logic                   as_s;
    logic                   ds_s;
    logic [5:0]             tmo_cnt_inc;
    logic [2:0]             wait_cnt_inc;
    logic                   tmo_hit;

    // Either data strobe low counts as an active data phase
    always_comb begin
        as_sync_d = {as_sync_q[SYNC_STAGES-2:0], bus.as_n};
        ds_sync_d = {ds_sync_q[SYNC_STAGES-2:0], bus.uds_n & bus.lds_n};
    end

    assign as_s = as_sync_q[SYNC_STAGES-1];
    assign ds_s = ds_sync_q[SYNC_STAGES-1];

    // Both counters saturate so a stuck bus can never wrap them back to zero
    assign tmo_cnt_inc  = (tmo_cnt_q == 6'h3f) ? tmo_cnt_q : tmo_cnt_q + 6'd1;
    assign wait_cnt_inc = (wait_cnt_q == 3'h7) ? wait_cnt_q : wait_cnt_q + 3'd1;
    assign tmo_hit      = (tmo_cnt_inc == c_timeout);

    always_comb begin
        state_d      = state_q;
        rw_latched_d = rw_latched_q;
        dtack_n_d    = dtack_n_q;
        timeout_d    = 1'b0;
        wait_cnt_d   = wait_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        ds_active_d  = ~ds_s;

        case (state_q)
            Z2_IDLE: begin
                dtack_n_d  = 1'b1;
                wait_cnt_d = 3'd0;
                tmo_cnt_d  = 6'd0;
                if (!as_s) begin
                    state_d      = Z2_START;
                    rw_latched_d = bus.rw;
                end
            end

            Z2_START: begin
                tmo_cnt_d = tmo_cnt_inc;
                if (as_s) begin
                    state_d = Z2_IDLE;
                end else if (tmo_hit) begin
                    state_d   = Z2_END;
                    timeout_d = 1'b1;
                end else if (!bus.board_select) begin
                    state_d = Z2_END;
                end else if (rw_latched_q || !ds_s) begin
                    state_d = Z2_DATA;
                end
            end

            // Abort beats acknowledge; acknowledge beats timeout
            Z2_DATA: begin
                tmo_cnt_d  = tmo_cnt_inc;
                wait_cnt_d = wait_cnt_inc;
                if (as_s) begin
                    state_d   = Z2_IDLE;
                    dtack_n_d = 1'b1;
                end else if (bus.slave_ack || (wait_cnt_q == c_wait_states)) begin
                    state_d   = Z2_END;
                    dtack_n_d = 1'b0;
                end else if (tmo_hit) begin
                    state_d   = Z2_END;
                    timeout_d = 1'b1;
                end
            end

            Z2_END: begin
                if (as_s) begin
                    state_d   = Z2_IDLE;
                    dtack_n_d = 1'b1;
                end
            end

            default: begin
                state_d   = Z2_IDLE;
                dtack_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= Z2_IDLE;
            as_sync_q    <= '1;
            ds_sync_q    <= '1;
            rw_latched_q <= 1'b1;
            ds_active_q  <= 1'b0;
            dtack_n_q    <= 1'b1;
            timeout_q    <= 1'b0;
            wait_cnt_q   <= 3'd0;
            tmo_cnt_q    <= 6'd0;
        end else begin
            state_q      <= state_d;
            as_sync_q    <= as_sync_d;
            ds_sync_q    <= ds_sync_d;
            rw_latched_q <= rw_latched_d;
            ds_active_q  <= ds_active_d;
            dtack_n_q    <= dtack_n_d;
            timeout_q    <= timeout_d;
            wait_cnt_q   <= wait_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign bus.z2_state   = state_q;
    assign bus.rw_latched = rw_latched_q;
    assign bus.ds_active  = ds_active_q;
    assign bus.dtack_n    = dtack_n_q;
    assign bus.timeout    = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_z2_cycle_tracker.sv
// ============================================================================
// Module      : tb_z2_cycle_tracker
// Description : Scoreboard bench; expected state transitions queued per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_z2_cycle_tracker;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_START = 2'b01;
    localparam logic [1:0] S_DATA  = 2'b10;
    localparam logic [1:0] S_END   = 2'b11;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    z2_cycle_tracker_if bus0 ();
    z2_cycle_tracker_if bus7 ();

    z2_cycle_tracker #(.SYNC_STAGES(2), .WAIT_STATES(0), .TIMEOUT(63)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    z2_cycle_tracker #(.SYNC_STAGES(2), .WAIT_STATES(7), .TIMEOUT(63)) u_dut7 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus7)
    );

    // dwell = clocks spent in from_s; 0 in an expected entry means "don't care"
    typedef struct packed {
        logic       dut;
        logic [1:0] from_s;
        logic [1:0] to_s;
        logic [7:0] dwell;
        logic       dtack_n;
        logic       rwl;
        logic       dsa;
        logic       tmo;
    } tr_t;

    tr_t        exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [1:0] prev_s [2] = '{2'b00, 2'b00};
    logic [7:0] dwell  [2] = '{8'd0, 8'd0};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic d, input logic [1:0] f, input logic [1:0] t, input int dw,
                        input logic dt, input logic rwl, input logic dsa, input logic tmo);
        exp_q.push_back(tr_t'{d, f, t, 8'(dw), dt, rwl, dsa, tmo});
    endtask

    task automatic observe(input bit k, input logic [1:0] s, input logic dt,
                           input logic rwl, input logic dsa, input logic tmo);
        tr_t act;
        tr_t e;
        if (dt === 1'b0) begin
            n_vec++;
            if (s !== S_END) begin
                n_err++;
                $display("FAIL dtack_outside_end dut%0d: state %0d, required %0d", k, s, S_END);
            end
        end
        if (s !== prev_s[k]) begin
            act = tr_t'{k, prev_s[k], s, dwell[k], dt, rwl, dsa, tmo};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL transition dut%0d: unexpected %0d->%0d", k, prev_s[k], s);
            end else begin
                e = exp_q.pop_front();
                if (e.dwell == 8'd0) act.dwell = 8'd0;
                if (act !== e) begin
                    n_err++;
                    $display("FAIL transition dut%0d: got %0d->%0d dwell=%0d dtack_n=%b rwl=%b ds=%b tmo=%b, want dut%0d %0d->%0d dwell=%0d dtack_n=%b rwl=%b ds=%b tmo=%b",
                             k, act.from_s, act.to_s, act.dwell, act.dtack_n, act.rwl, act.dsa, act.tmo,
                             e.dut, e.from_s, e.to_s, e.dwell, e.dtack_n, e.rwl, e.dsa, e.tmo);
                end
            end
            prev_s[k] = s;
            dwell[k]  = 8'd1;
        end else if (dwell[k] != 8'hff) begin
            dwell[k] = dwell[k] + 8'd1;
        end
    endtask

    always @(negedge clk) begin
        observe(1'b0, bus0.z2_state, bus0.dtack_n, bus0.rw_latched, bus0.ds_active, bus0.timeout);
        observe(1'b1, bus7.z2_state, bus7.dtack_n, bus7.rw_latched, bus7.ds_active, bus7.timeout);
    end

    task automatic drv(input bit sel, input logic a, input logic u, input logic l,
                       input logic r, input logic b, input logic k);
        if (sel) begin
            bus7.as_n = a; bus7.uds_n = u; bus7.lds_n = l;
            bus7.rw = r; bus7.board_select = b; bus7.slave_ack = k;
        end else begin
            bus0.as_n = a; bus0.uds_n = u; bus0.lds_n = l;
            bus0.rw = r; bus0.board_select = b; bus0.slave_ack = k;
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        drv(1'b0, 1, 1, 1, 1, 0, 0);
        drv(1'b1, 1, 1, 1, 1, 0, 0);
        clks(3);
        reset = 1'b0;
        clks(2);

        chk("rst_state0",  8'(bus0.z2_state),   8'd0);
        chk("rst_dtack0",  8'(bus0.dtack_n),    8'd1);
        chk("rst_rwl0",    8'(bus0.rw_latched), 8'd1);
        chk("rst_ds0",     8'(bus0.ds_active),  8'd0);
        chk("rst_tmo0",    8'(bus0.timeout),    8'd0);
        chk("rst_state7",  8'(bus7.z2_state),   8'd0);
        chk("rst_dtack7",  8'(bus7.dtack_n),    8'd1);
        chk("rst_rwl7",    8'(bus7.rw_latched), 8'd1);
        chk("rst_ds7",     8'(bus7.ds_active),  8'd0);
        chk("rst_tmo7",    8'(bus7.timeout),    8'd0);

        // Read, zero wait states
        push(0, S_IDLE,  S_START, 0, 1, 1, 1, 0);
        push(0, S_START, S_DATA,  1, 1, 1, 1, 0);
        push(0, S_DATA,  S_END,   1, 0, 1, 1, 0);
        push(0, S_END,   S_IDLE,  6, 1, 1, 0, 0);
        drv(1'b0, 0, 0, 0, 1, 1, 0); clks(8);
        drv(1'b0, 1, 1, 1, 1, 1, 0); clks(6);

        // Write, data strobe three clocks behind AS
        push(0, S_IDLE,  S_START, 0, 1, 0, 0, 0);
        push(0, S_START, S_DATA,  3, 1, 0, 1, 0);
        push(0, S_DATA,  S_END,   1, 0, 0, 1, 0);
        push(0, S_END,   S_IDLE,  6, 1, 0, 0, 0);
        drv(1'b0, 0, 1, 1, 0, 1, 0); clks(3);
        drv(1'b0, 0, 1, 0, 0, 1, 0); clks(7);
        drv(1'b0, 1, 1, 1, 0, 1, 0); clks(6);

        // Cycle not for this board
        push(0, S_IDLE,  S_START, 0, 1, 1, 1, 0);
        push(0, S_START, S_END,   1, 1, 1, 1, 0);
        push(0, S_END,   S_IDLE,  7, 1, 1, 0, 0);
        drv(1'b0, 0, 0, 0, 1, 0, 0); clks(8);
        drv(1'b0, 1, 1, 1, 1, 0, 0); clks(6);

        // Autoconfig read, ack on second DATA clock
        push(1, S_IDLE,  S_START, 0, 1, 1, 1, 0);
        push(1, S_START, S_DATA,  1, 1, 1, 1, 0);
        push(1, S_DATA,  S_END,   2, 0, 1, 1, 0);
        push(1, S_END,   S_IDLE,  7, 1, 1, 0, 0);
        drv(1'b1, 0, 0, 0, 1, 1, 0); clks(5);
        drv(1'b1, 0, 0, 0, 1, 1, 1); clks(1);
        drv(1'b1, 0, 0, 0, 1, 1, 0); clks(4);
        drv(1'b1, 1, 1, 1, 1, 1, 0); clks(6);

        // RAM read with seven wait states
        push(1, S_IDLE,  S_START, 0, 1, 1, 1, 0);
        push(1, S_START, S_DATA,  1, 1, 1, 1, 0);
        push(1, S_DATA,  S_END,   8, 0, 1, 1, 0);
        push(1, S_END,   S_IDLE,  5, 1, 1, 0, 0);
        drv(1'b1, 0, 0, 0, 1, 1, 0); clks(14);
        drv(1'b1, 1, 1, 1, 1, 1, 0); clks(6);

        // Master abort coinciding with slave_ack
        push(1, S_IDLE,  S_START, 0, 1, 1, 1, 0);
        push(1, S_START, S_DATA,  1, 1, 1, 1, 0);
        push(1, S_DATA,  S_IDLE,  3, 1, 1, 0, 0);
        drv(1'b1, 0, 0, 0, 1, 1, 0); clks(4);
        drv(1'b1, 1, 1, 1, 1, 1, 0); clks(2);
        drv(1'b1, 1, 1, 1, 1, 1, 1); clks(1);
        drv(1'b1, 1, 1, 1, 1, 1, 0); clks(4);

        // Hung write: no DS, no ack
        push(1, S_IDLE,  S_START, 0,  1, 0, 0, 0);
        push(1, S_START, S_END,   63, 1, 0, 0, 1);
        push(1, S_END,   S_IDLE,  7,  1, 0, 0, 0);
        drv(1'b1, 0, 1, 1, 0, 1, 0); clks(67);
        chk("timeout_pulse_width", 8'(bus7.timeout),  8'd0);
        chk("hang_state",          8'(bus7.z2_state), 8'(S_END));
        chk("hang_dtack",          8'(bus7.dtack_n),  8'd1);
        clks(3);
        drv(1'b1, 1, 1, 1, 1, 1, 0); clks(6);

        // Reset in DATA with dtack pending, AS held through release
        push(1, S_IDLE,  S_START, 0, 1, 1, 1, 0);
        push(1, S_START, S_DATA,  1, 1, 1, 1, 0);
        push(1, S_DATA,  S_IDLE,  3, 1, 1, 0, 0);
        push(1, S_IDLE,  S_START, 4, 1, 1, 1, 0);
        push(1, S_START, S_DATA,  1, 1, 1, 1, 0);
        push(1, S_DATA,  S_END,   8, 0, 1, 1, 0);
        push(1, S_END,   S_IDLE,  5, 1, 1, 0, 0);
        drv(1'b1, 0, 0, 0, 1, 1, 0); clks(6);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_state", 8'(bus7.z2_state),  8'd0);
        chk("async_rst_dtack", 8'(bus7.dtack_n),   8'd1);
        chk("async_rst_ds",    8'(bus7.ds_active), 8'd0);
        clks(2);
        reset = 1'b0;
        clks(14);
        drv(1'b1, 1, 1, 1, 1, 1, 0); clks(6);

        clks(2);
        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
